regbank_wb_arbiter: RTL and testbench
=====================================

Name: regbank_wb_arbiter

Overview:
- Shares the register bank's single write port between NREQ write-back requesters: ALU, load unit and multiply unit.
- Arbitrates with a round-robin pointer and drives the bank's Regwrite/Write_reg/Write_data from registers.
- Keeps a 16-bit pending-write scoreboard so the issue stage can stall on RAW hazards.
- Sits between the execute/memory stages and the register bank.

Parameters:
- NREQ, 3, number of write-back requesters (index 0 ALU, 1 LOAD, 2 MUL).
- DW, 16, data width.
- AW, 4, register index width (2**AW registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester write-back request.
- req_reg  in  NREQ*AW  destination index, requester i at bits [i*AW +: AW].
- req_data  in  NREQ*DW  write data, requester i at bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant, combinational.
- rsv_valid  in  1  issue stage reserves a destination this cycle.
- rsv_reg  in  AW  destination index being reserved.
- busy_mask  out  2**AW  registered scoreboard; bit r=1 means a write to Rr is pending.
- Regwrite  out  1  registered write enable to the register bank.
- Write_reg  out  AW  registered write index.
- Write_data  out  DW  registered write data.
- grant_id  out  2  registered index of the requester that produced the current Regwrite.

Behaviour:
- Reset (synchronous, active-high):
  - Regwrite=0, Write_reg=0, Write_data=0, grant_id=0, busy_mask=0, rr_ptr=0.
  - req_ready=0 while rst=1.
  - Any request or reservation in flight at reset is discarded. Requesters must re-present after rst deasserts.
- Handshake:
  - A transfer occurs on a rising edge where req_valid[i]&req_ready[i].
  - Once req_valid[i] is raised, it and its reg/data must stay stable until accepted.
  - A requester never sees ready without valid.
- Arbitration:
  - At most one grant per cycle.
  - Search order: rr_ptr, rr_ptr+1, ... mod NREQ. The first valid requester gets req_ready.
  - After a grant to i, rr_ptr <= (i+1) mod NREQ. With no grant, rr_ptr holds.
  - Wrap from NREQ-1 goes to 0.
- Write port:
  - Latency is 1 cycle. The edge that accepts requester i loads Write_reg<=req_reg[i], Write_data<=req_data[i], grant_id<=i.
  - On that edge Regwrite<=1 unless req_reg[i]==0. A write to R0 is accepted (ready high) but Regwrite<=0.
  - With no grant, Regwrite<=0; Write_reg, Write_data and grant_id hold.
  - Back-to-back grants produce Regwrite high on consecutive cycles.
- Scoreboard, evaluated on each edge:
  - clear: a grant to a requester with req_reg=r, r!=0, clears busy_mask[r].
  - set: rsv_valid with rsv_reg=r, r!=0, sets busy_mask[r].
  - Set and clear of the same r on the same edge: set wins, so the new reservation survives.
  - busy_mask[0] is always 0. Reserving R0 is ignored.
  - Reserving an already-busy register keeps it busy. There is no counting; the issue stage must not double-reserve.
- FSM: none beyond rr_ptr. The sequential state is rr_ptr, the output registers and busy_mask.
- Widths: NREQ<=4, so grant_id is 2 bits. Index slicing is unsigned.

Decomposition:
- Shared package regbank_pkg holds the AW/DW constants, the requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_MUL=2, and the R0 index constant.
- One sub-module is natural: rr_arbiter (NREQ-wide round-robin, valid in, one-hot grant out, pointer update on accept). The scoreboard and output registers stay in the top.

Test Plan:
- Reset: drive rst=1 with req_valid=3'b111 -> req_ready=0, Regwrite=0, busy_mask=0. After rst drops, the first grant is index 0.
- Single write: ALU req R5, data 16'hA5A5 at cycle t -> req_ready[0]=1 at t; at t+1 Regwrite=1, Write_reg=5, Write_data=16'hA5A5, grant_id=0; at t+2 Regwrite=0.
- Round-robin: all three requesters held valid, writing R1/R2/R3, starting with rr_ptr=0 -> grants 0,1,2 on consecutive cycles, Regwrite high 3 cycles, Write_reg sequence 1,2,3.
- Wrap-around: rr_ptr=2 with only req 0 and req 2 valid -> req 2 is granted first, then req 0 the next cycle, after which rr_ptr=1.
- R0 write: LOAD req R0, data 16'hFFFF -> req_ready[1]=1, Regwrite stays 0 the next cycle, busy_mask unchanged.
- Scoreboard:
  - Reserve R7 -> busy_mask[7]=1 after the edge. A later MUL grant to R7 clears it.
  - Reserve R7 on the same edge as a grant to R7 -> busy_mask[7] stays 1.
  - rst mid-pending -> busy_mask=0.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared constants for the register-bank write-back path: widths, requester indices, R0.
package regbank_pkg;
    localparam int AW       = 4;
    localparam int DW       = 16;
    localparam int NREQ     = 3;
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_MUL  = 2;
    localparam logic [AW-1:0] R0 = '0;
endpackage

// File: rtl/regbank_wb_arbiter_rr_arbiter.sv
// NREQ-wide round-robin arbiter: combinational one-hot grant searched from the pointer.
// Latency 0 (grant), pointer advances past the winner on the accepting edge; grants drop while rst.
module regbank_wb_arbiter_rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant,
    output logic [1:0]      grant_idx,
    output logic            grant_any
);
    logic [1:0] ptr;
    int         idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(ptr) + k) % NREQ;
                if (!grant_any && valid[idx]) begin
                    grant_any  = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = 2'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            if (int'(grant_idx) == NREQ - 1)
                ptr <= '0;
            else
                ptr <= grant_idx + 2'd1;
        end
    end
endmodule

// File: rtl/regbank_wb_arbiter.sv
// Shares the register bank write port among NREQ write-back requesters; keeps a pending-write scoreboard.
// Latency 1 cycle from accept to Regwrite; a requester holds valid until its one-hot ready.
module regbank_wb_arbiter
    import regbank_pkg::*;
#(
    parameter int NREQ_P = NREQ,
    parameter int DW_P   = DW,
    parameter int AW_P   = AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ_P-1:0]    req_valid,
    input  logic [NREQ_P*AW_P-1:0] req_reg,
    input  logic [NREQ_P*DW_P-1:0] req_data,
    output logic [NREQ_P-1:0]    req_ready,
    input  logic                 rsv_valid,
    input  logic [AW_P-1:0]      rsv_reg,
    output logic [2**AW_P-1:0]   busy_mask,
    output logic                 Regwrite,
    output logic [AW_P-1:0]      Write_reg,
    output logic [DW_P-1:0]      Write_data,
    output logic [1:0]           grant_id
);
    logic [1:0]          grant_idx;
    logic                grant_any;
    logic [AW_P-1:0]     sel_reg;
    logic [DW_P-1:0]     sel_data;
    logic [2**AW_P-1:0]  busy_nxt;

    regbank_wb_arbiter_rr_arbiter #(.NREQ(NREQ_P)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (req_valid),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign sel_reg  = req_reg[grant_idx*AW_P +: AW_P];
    assign sel_data = req_data[grant_idx*DW_P +: DW_P];

    // Clear before set so a same-edge reservation of the retiring register survives.
    always_comb begin
        busy_nxt = busy_mask;
        if (grant_any && sel_reg != R0)
            busy_nxt[sel_reg] = 1'b0;
        if (rsv_valid && rsv_reg != R0)
            busy_nxt[rsv_reg] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask  <= '0;
            Regwrite   <= 1'b0;
            Write_reg  <= '0;
            Write_data <= '0;
            grant_id   <= '0;
        end else begin
            busy_mask <= busy_nxt;
            Regwrite  <= grant_any && (sel_reg != R0);
            if (grant_any) begin
                Write_reg  <= sel_reg;
                Write_data <= sel_data;
                grant_id   <= grant_idx;
            end
        end
    end
endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter with a reference model feeding an expected-output queue.
module tb_regbank_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [11:0] req_reg;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        rsv_valid;
    logic [3:0]  rsv_reg;
    logic [15:0] busy_mask;
    logic        Regwrite;
    logic [3:0]  Write_reg;
    logic [15:0] Write_data;
    logic [1:0]  grant_id;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rw;
        logic [3:0]  wreg;
        logic [15:0] wdata;
        logic [1:0]  gid;
        logic [15:0] busy;
    } exp_t;
    exp_t exp_q[$];

    int          m_ptr  = 0;
    logic        m_rw   = 1'b0;
    logic [3:0]  m_wreg = '0;
    logic [15:0] m_wdata = '0;
    logic [1:0]  m_gid  = '0;
    logic [15:0] m_busy = '0;

    regbank_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_reg    (req_reg),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsv_valid  (rsv_valid),
        .rsv_reg    (rsv_reg),
        .busy_mask  (busy_mask),
        .Regwrite   (Regwrite),
        .Write_reg  (Write_reg),
        .Write_data (Write_data),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] r, input logic [15:0] d);
        req_valid[i]       = 1'b1;
        req_reg[i*4 +: 4]  = r;
        req_data[i*16 +: 16] = d;
    endtask

    // One clock: check ready, predict next outputs, advance, compare; granted requesters then drop valid.
    task automatic step(input logic r);
        int   g;
        int   idx;
        logic [2:0] exp_rdy;
        exp_t e;
        #1;
        g = -1;
        if (!r) begin
            for (int k = 0; k < 3; k++) begin
                idx = (m_ptr + k) % 3;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
        chk("req_ready", 48'(req_ready), 48'(exp_rdy));

        if (r) begin
            m_ptr = 0; m_rw = 0; m_wreg = '0; m_wdata = '0; m_gid = '0; m_busy = '0;
        end else begin
            m_rw = 1'b0;
            if (g >= 0) begin
                m_wreg  = req_reg[g*4 +: 4];
                m_wdata = req_data[g*16 +: 16];
                m_gid   = 2'(g);
                m_rw    = (m_wreg != 4'd0);
                m_ptr   = (g + 1) % 3;
                if (m_wreg != 4'd0) m_busy[m_wreg] = 1'b0;
            end
            if (rsv_valid && rsv_reg != 4'd0) m_busy[rsv_reg] = 1'b1;
        end
        e.rw = m_rw; e.wreg = m_wreg; e.wdata = m_wdata; e.gid = m_gid; e.busy = m_busy;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("Regwrite",   48'(Regwrite),   48'(e.rw));
        chk("Write_reg",  48'(Write_reg),  48'(e.wreg));
        chk("Write_data", 48'(Write_data), 48'(e.wdata));
        chk("grant_id",   48'(grant_id),   48'(e.gid));
        chk("busy_mask",  48'(busy_mask),  48'(e.busy));
        if (g >= 0) req_valid[g] = 1'b0;
        rsv_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 3'b111; req_reg = '0; req_data = '0;
        rsv_valid = 1'b0; rsv_reg = '0;
        set_req(0, 4'd1, 16'h1111);
        set_req(1, 4'd2, 16'h2222);
        set_req(2, 4'd3, 16'h3333);
        @(posedge clk);
        step(1'b1);
        step(1'b1);
        chk("rst_ready_zero", 48'(req_ready), 48'd0);
        chk("rst_busy_zero", 48'(busy_mask), 48'd0);

        // Round robin from pointer 0 with all three held valid.
        rst = 1'b0;
        #1 chk("first_grant_alu", 48'(req_ready), 48'(3'b001));
        step(1'b0);
        chk("rr_wreg1", 48'(Write_reg), 48'd1);
        step(1'b0);
        chk("rr_wreg2", 48'(Write_reg), 48'd2);
        step(1'b0);
        chk("rr_wreg3", 48'(Write_reg), 48'd3);
        step(1'b0);
        chk("idle_regwrite", 48'(Regwrite), 48'd0);

        // Single ALU write.
        set_req(0, 4'd5, 16'hA5A5);
        step(1'b0);
        chk("single_data", 48'(Write_data), 48'hA5A5);
        step(1'b0);

        // Move pointer to 2, then wrap: MUL before ALU, pointer ends at 1.
        set_req(1, 4'd4, 16'h4444);
        step(1'b0);
        set_req(0, 4'd6, 16'h6666);
        set_req(2, 4'd8, 16'h8888);
        step(1'b0);
        chk("wrap_first_mul", 48'(grant_id), 48'd2);
        step(1'b0);
        chk("wrap_second_alu", 48'(grant_id), 48'd0);
        set_req(0, 4'd9, 16'h9999);
        set_req(1, 4'd10, 16'hAAAA);
        step(1'b0);
        chk("ptr_after_wrap", 48'(grant_id), 48'd1);
        step(1'b0);

        // R0 write: accepted but no bank write.
        set_req(1, 4'd0, 16'hFFFF);
        step(1'b0);
        chk("r0_no_write", 48'(Regwrite), 48'd0);

        // Scoreboard set, clear, same-edge set-wins, R0 reserve ignored.
        rsv_valid = 1'b1; rsv_reg = 4'd7;
        step(1'b0);
        chk("sb_r7_set", 48'(busy_mask[7]), 48'd1);
        rsv_valid = 1'b1; rsv_reg = 4'd0;
        step(1'b0);
        set_req(2, 4'd7, 16'h7777);
        step(1'b0);
        chk("sb_r7_cleared", 48'(busy_mask[7]), 48'd0);
        rsv_valid = 1'b1; rsv_reg = 4'd7;
        step(1'b0);
        set_req(2, 4'd7, 16'h7070);
        rsv_valid = 1'b1; rsv_reg = 4'd7;
        step(1'b0);
        chk("sb_set_wins", 48'(busy_mask[7]), 48'd1);
        rsv_valid = 1'b1; rsv_reg = 4'd12;
        step(1'b0);

        // Reset with writes pending.
        rst = 1'b1;
        set_req(0, 4'd3, 16'h0303);
        step(1'b1);
        chk("rst_mid_busy", 48'(busy_mask), 48'd0);
        rst = 1'b0;
        step(1'b0);
        step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
